// File: rtl/raw_hits_readout_pkg.sv
// Shared constants, FSM state encoding and word type for the raw hit window readout.
// Used by the capture RAM and the readout controller.
package raw_hits_readout_pkg;

    localparam int WIDTH         = 576;
    localparam int WORD_W        = 16;
    localparam int WORDS_PER_BIN = WIDTH / WORD_W;
    localparam int TB_W          = 5;
    localparam int DEPTH         = 1 << TB_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_READ    = 2'd2;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/raw_hits_readout_capture_ram.sv
// Simple dual-port 32x576 block RAM: one write port, one read port with a
// registered output (one cycle latency). Contents are never reset.
module raw_capture_ram
    import raw_hits_readout_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [TB_W-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [TB_W-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register holds its value between reads; the readout relies on that.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/raw_hits_readout.sv
// Captures a trigger-selected window of raw hit bins into block RAM and streams
// it out as 16-bit words with a valid/ready handshake.
module raw_hits_readout
    import raw_hits_readout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  raw_in,
    input  logic              trig,
    input  logic [TB_W-1:0]   tbins,
    output logic              busy,
    output logic              trig_lost,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last
);

    // Handshake: a word transfers in every cycle where dout_valid and dout_ready
    // are both high; while valid is high and ready low, dout/dout_last hold.

    logic [1:0]       r_state;
    logic [TB_W-1:0]  r_n;
    logic [TB_W:0]    r_bin;
    logic [5:0]       r_word;
    logic [WIDTH-1:0] r_hold;
    logic             r_valid;
    logic             r_fill;
    logic             r_trig_lost;

    logic             w_we;
    logic [TB_W-1:0]  w_waddr;
    logic             w_re;
    logic [TB_W-1:0]  w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_accept;
    logic             w_word_last;
    logic             w_last_bin;
    logic [TB_W:0]    w_next_bin;

    assign w_accept    = r_valid && dout_ready;
    assign w_word_last = (r_word == 6'(WORDS_PER_BIN - 1));
    assign w_last_bin  = (r_bin == {1'b0, r_n});
    assign w_next_bin  = r_bin + 1'b1;

    assign w_we    = ((r_state == ST_IDLE) && trig) || (r_state == ST_CAPTURE);
    assign w_waddr = (r_state == ST_CAPTURE) ? r_bin[TB_W-1:0] : '0;

    // First read loads bin 0; afterwards the next bin is fetched while word 34
    // is on the bus so the bin boundary costs no cycle. Repeated reads during a
    // stall return the same data because nothing is written in READ.
    assign w_re    = (r_state == ST_READ) &&
                     ((!r_valid && !r_fill) ||
                      (r_valid && (r_word == 6'(WORDS_PER_BIN - 2))));
    assign w_raddr = r_valid ? w_next_bin[TB_W-1:0] : '0;

    raw_capture_ram u_ram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (raw_in),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_bin       <= '0;
            r_word      <= '0;
            r_hold      <= '0;
            r_valid     <= 1'b0;
            r_fill      <= 1'b0;
            r_trig_lost <= 1'b0;
        end else begin
            r_trig_lost <= trig && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (trig) begin
                        r_n    <= tbins;
                        r_word <= '0;
                        if (tbins == '0) begin
                            r_bin   <= '0;
                            r_state <= ST_READ;
                        end else begin
                            r_bin   <= (TB_W+1)'(1);
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (w_last_bin) begin
                        r_bin   <= '0;
                        r_state <= ST_READ;
                    end else begin
                        r_bin <= w_next_bin;
                    end
                end
                ST_READ: begin
                    if (r_fill) begin
                        r_hold  <= w_rdata;
                        r_valid <= 1'b1;
                        r_fill  <= 1'b0;
                    end else if (!r_valid) begin
                        r_fill <= 1'b1;
                    end else if (w_accept) begin
                        if (!w_word_last) begin
                            r_word <= r_word + 1'b1;
                        end else if (w_last_bin) begin
                            r_valid <= 1'b0;
                            r_word  <= '0;
                            r_bin   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_hold <= w_rdata;
                            r_bin  <= w_next_bin;
                            r_word <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign trig_lost  = r_trig_lost;
    assign dout_valid = r_valid;
    assign dout       = r_hold[{r_word, 4'b0000} +: WORD_W];
    assign dout_last  = r_valid && w_word_last && w_last_bin;

endmodule

// File: tb/tb_raw_hits_readout.sv
// Scoreboard bench for raw_hits_readout: capture tasks queue the expected words,
// a monitor pops and compares them on every accepted output word.
module tb_raw_hits_readout;
    import raw_hits_readout_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  raw_in;
    logic              trig;
    logic [TB_W-1:0]   tbins;
    logic              busy;
    logic              trig_lost;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;

    logic [WORD_W:0]   exp_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                acc_cnt = 0;
    int                lost_cnt = 0;
    int                t_first = -1;
    int                t_last = -1;
    int                rdy_mode = 0;
    int                rp = 0;
    logic [WORD_W-1:0] first_word;
    logic              held_v = 1'b0;
    logic [WORD_W:0]   held;
    logic              chk_idle = 1'b0;

    always #5 clk = ~clk;

    raw_hits_readout dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .trig       (trig),
        .tbins      (tbins),
        .busy       (busy),
        .trig_lost  (trig_lost),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0: bit k set when k mod 3 == 0; kind 1: bin index in every slice;
    // other kinds: slice = kind pattern xor {bin, word index}.
    function automatic logic [WIDTH-1:0] mk_bin(input int kind, input int b);
        logic [WIDTH-1:0] v;
        word_t s;
        for (int w = 0; w < WORDS_PER_BIN; w++) begin
            if (kind == 0) begin
                for (int j = 0; j < WORD_W; j++) s[j] = ((w * WORD_W + j) % 3 == 0);
            end else if (kind == 1) begin
                s = word_t'(b);
            end else begin
                s = word_t'(kind * 32'h1111) ^ word_t'((b << 8) | w);
            end
            v[w*WORD_W +: WORD_W] = s;
        end
        return v;
    endfunction

    // Called at posedge+#1; trig_at > 0 pulses an extra trig (tbins=7) during capture.
    task automatic start_capture(input int n, input int kind, input int trig_at);
        logic [WIDTH-1:0] v;
        for (int b = 0; b <= n; b++) begin
            v = mk_bin(kind, b);
            for (int w = 0; w < WORDS_PER_BIN; w++)
                exp_q.push_back({(b == n) && (w == WORDS_PER_BIN - 1), v[w*WORD_W +: WORD_W]});
        end
        trig   = 1'b1;
        tbins  = 5'(n);
        raw_in = mk_bin(kind, 0);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            raw_in = mk_bin(kind, i);
            trig   = (i == trig_at);
            if (i == trig_at) tbins = 5'd7;
        end
        @(posedge clk); #1;
        trig   = 1'b0;
        raw_in = {18{32'hDEADBEEF}};
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check($sformatf("%s idle", name), 32'(busy), 0);
        check($sformatf("%s words left", name), exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check($sformatf("%s busy", name), 32'(busy), 0);
        check($sformatf("%s trig_lost", name), 32'(trig_lost), 0);
        check($sformatf("%s dout", name), 32'(dout), 0);
        check($sformatf("%s dout_valid", name), 32'(dout_valid), 0);
        check($sformatf("%s dout_last", name), 32'(dout_last), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                dout_ready = 1'b1;
            end else begin
                dout_ready = (rp % 4 == 0) || (rp % 4 == 3);
                rp++;
            end
        end
    end

    // Monitor
    initial forever begin
        logic [WORD_W:0] e;
        @(negedge clk);
        if (rst) begin
            held_v   = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (trig_lost) lost_cnt++;
            if (chk_idle) begin
                check("idle after last", {30'd0, busy, dout_valid}, 0);
                chk_idle = 1'b0;
            end
            if (held_v) begin
                check("stall valid", 32'(dout_valid), 1);
                check("stall hold", 32'({dout_last, dout}), 32'(held));
            end
            held_v = 1'b0;
            if (dout_valid) begin
                if (!dout_ready) begin
                    held_v = 1'b1;
                    held   = {dout_last, dout};
                end else begin
                    acc_cnt++;
                    if (t_first < 0) begin
                        t_first    = cyc;
                        first_word = dout;
                    end
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected word: got %0h expected none", dout);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("word %0d", acc_cnt), 32'({dout_last, dout}), 32'(e));
                    end
                    if (dout_last) begin
                        t_last   = cyc;
                        chk_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int t_trig;
        int l0;
        int k;
        rst    = 1'b1;
        trig   = 1'b0;
        tbins  = '0;
        raw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single bin, mod-3 pattern
        acc_cnt = 0;
        t_first = -1;
        t_trig  = cyc;
        start_capture(0, 0, -1);
        wait_idle("t1");
        check("t1 word0", 32'(first_word), 32'h9249);
        check("t1 count", acc_cnt, 36);
        check("t1 latency ok", 32'((t_first - t_trig) <= 4), 1);

        // Full 32-bin window, gap-free
        acc_cnt = 0;
        t_first = -1;
        start_capture(31, 1, -1);
        wait_idle("t2");
        check("t2 count", acc_cnt, 1152);
        check("t2 gapless span", t_last - t_first, 1151);

        // Backpressure 1,0,0,1
        acc_cnt  = 0;
        rp       = 0;
        rdy_mode = 1;
        start_capture(2, 2, -1);
        wait_idle("t3");
        rdy_mode = 0;
        check("t3 count", acc_cnt, 108);

        // Triggers during CAPTURE and READ are lost
        acc_cnt = 0;
        l0      = lost_cnt;
        start_capture(3, 3, 2);
        k = 0;
        while (!dout_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4 reached read", 32'(dout_valid), 1);
        trig  = 1'b1;
        tbins = 5'd9;
        @(posedge clk); #1;
        trig = 1'b0;
        wait_idle("t4");
        check("t4 count", acc_cnt, 144);
        check("t4 lost pulses", lost_cnt - l0, 2);

        // Reset in the middle of readout
        acc_cnt = 0;
        start_capture(4, 4, -1);
        k = 0;
        while (acc_cnt < 50 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5 reached word 50", 32'(acc_cnt >= 50), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5 mid reset");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        acc_cnt = 0;
        start_capture(0, 5, -1);
        wait_idle("t5 after");
        check("t5 count", acc_cnt, 36);

        // Back-to-back: trig right after busy falls is accepted,
        // trig in the last-acceptance cycle is lost
        acc_cnt = 0;
        l0      = lost_cnt;
        start_capture(0, 6, -1);
        wait_idle("t6a");
        start_capture(0, 7, -1);
        check("t6 accepted busy", 32'(busy), 1);
        k = 0;
        while (!(dout_valid && dout_last && dout_ready) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6 reached last", 32'(dout_last), 1);
        trig  = 1'b1;
        tbins = 5'd3;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        wait_idle("t6b");
        check("t6 count", acc_cnt, 72);
        check("t6 lost pulses", lost_cnt - l0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raw_hits_readout.md
Name: raw_hits_readout

Overview:
- Captures a trigger-selected window of delayed raw wire hits from the 576-bit raw hit delay line output (the delay stage's dout), directly downstream of that stage.
- Stores up to 32 time bins in block RAM.
- Streams the stored bins to the DAQ formatter as 16-bit words with a valid/ready handshake.
- One capture is in flight at a time. Triggers arriving while busy are dropped and flagged.

Parameters:
- WIDTH, 576, raw hit vector width (wires per time bin)
- WORD_W, 16, readout word width
- WORDS_PER_BIN, 36, WIDTH/WORD_W
- TB_W, 5, time-bin counter width; maximum 2^TB_W = 32 bins

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- raw_in  in  576  delayed raw hits, one time bin per clk
- trig  in  1  capture request, single-cycle pulse
- tbins  in  5  bins to capture minus one (0 means 1 bin, 31 means 32 bins); sampled at accepted trig
- busy  out  1  high from accepted trig until the last word is accepted
- trig_lost  out  1  one-cycle pulse when trig arrives while busy
- dout  out  16  readout word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout when valid and ready in the same cycle
- dout_last  out  1  qualifies the final word of the capture

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: busy=0, trig_lost=0, dout=0, dout_valid=0, dout_last=0, state=IDLE, all counters 0. RAM contents are not cleared.
- Reset mid-operation aborts immediately: capture or readout is discarded, no dout_last is produced.
- FSM states are IDLE, CAPTURE, READ.
- IDLE:
  - trig=1: write raw_in (the trig-cycle bin) to RAM[0], latch n=tbins, bin counter=1, busy=1 next cycle.
  - If n==0, go to READ; otherwise go to CAPTURE.
- CAPTURE:
  - Each cycle write raw_in to RAM[bin] and increment bin.
  - When the written bin equals n, go to READ. Captured bins are exactly trig cycle .. trig cycle+n.
- READ:
  - Issue a RAM read for bin b; RAM read latency is 1 cycle into a 576-bit holding register.
  - Word w of bin b is holding[16w+15:16w]. Order: b=0..n outer loop, w=0..35 inner loop.
  - First dout_valid is asserted no later than 3 cycles after entering READ.
  - dout and dout_last are stable while dout_valid=1 and dout_ready=0.
  - With dout_ready held high, one word is accepted per cycle, with no gaps at bin boundaries (prefetch the next bin during words 34/35).
  - Total words = 36*(n+1). dout_last=1 only on word 35 of bin n.
  - On acceptance of the last word: dout_valid=0, busy=0, return to IDLE in the next cycle.
  - trig in the same cycle as last-word acceptance counts as busy and is lost.
- trig in CAPTURE or READ produces a trig_lost pulse. It does not alter the in-progress capture, and the tbins value at that time is ignored.
- tbins changes outside an accepted trig have no effect.
- Counters:
  - bin counter is TB_W+1 bits, so bin 31 is reached without wrap.
  - word counter runs 0..35 (6 bits).
  - No arithmetic wraps in any legal case.

Decomposition:
- Shared package:
  - constants WIDTH, WORD_W, WORDS_PER_BIN, TB_W
  - state encoding IDLE/CAPTURE/READ
  - readout word type
- Sub-module raw_capture_ram: simple dual-port 32x576 block RAM with one write port and a registered read port (1-cycle latency), synthesized as block RAM.
- The FSM, counters and output word mux stay in raw_hits_readout.

Test Plan:
- Single bin: tbins=0, raw_in=pattern with bit k = (k mod 3 == 0), trig once, dout_ready=1.
  - Expect exactly 36 words; word0=16'h9249, dout_last on word 35 only, busy falls after acceptance.
- Full window: tbins=31, raw_in = bin index replicated in every 16-bit slice.
  - Expect 1152 words; words 36b..36b+35 all equal b, gap-free with ready=1.
- Backpressure: tbins=2, dout_ready toggled 1,0,0,1 repeating.
  - Expect 108 words in order, dout/dout_last stable during stalls, none lost or duplicated.
- Trigger while busy: tbins=3, second trig during CAPTURE and third during READ.
  - Expect trig_lost pulses at both, still 144 words from the first capture only.
- Reset mid-readout: assert rst after word 50 of tbins=4.
  - Expect all outputs 0 immediately, busy=0.
  - A new trig with tbins=0 yields 36 fresh words with correct data.
- Back-to-back: trig in the cycle after busy falls.
  - Expect it accepted, no trig_lost; trig in the last-acceptance cycle gives trig_lost.
